// File: rtl/usr_pkg.sv
// usr_pkg: mode encodings and default width shared by the universal shift register
package usr_pkg;
  localparam int USR_DEFAULT_WIDTH = 8;
  localparam logic [2:0] USR_HOLD  = 3'b000;
  localparam logic [2:0] USR_SHL   = 3'b001;
  localparam logic [2:0] USR_SHR   = 3'b010;
  localparam logic [2:0] USR_ROL   = 3'b011;
  localparam logic [2:0] USR_ROR   = 3'b100;
  localparam logic [2:0] USR_LOAD  = 3'b101;
  localparam logic [2:0] USR_CLEAR = 3'b110;
endpackage

// File: rtl/usr_shift_counter.sv
// usr_shift_counter: counts serial shifts, wraps at WIDTH and pulses o_word_valid once per wrap
module usr_shift_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_word_valid
);
  localparam logic [CNT_W-1:0] TC = CNT_W'(WIDTH - 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_word_valid;
  logic             w_tc;
  assign w_tc = i_inc && (r_cnt == TC);
  // clear wins, terminal count wraps to zero and raises a one-cycle word pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_cnt        <= i_clr ? '0 : w_tc ? '0 : i_inc ? r_cnt + CNT_W'(1) : r_cnt;
      r_word_valid <= w_tc && !i_clr;
    end
  end
  assign o_cnt        = r_cnt;
  assign o_word_valid = r_word_valid;
endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: mode-selectable shift/rotate/load register with word framing; parity via USR_PARITY_EN
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH     = USR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdata_in,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_valid,
  output logic             parity
);
  logic [1:0]       r_rst_sync;
  logic             w_rst;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_inc;
  logic             w_clr;
  // assertion is immediate, release is held for two clock edges so it lands synchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rst_sync <= 2'b11;
    else     r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];
  // next-state mux; en=0 and the reserved encoding both hold
  always_comb begin
    w_next = r_q;
    if (en) begin
      case (mode)
        USR_SHL:   w_next = {r_q[WIDTH-2:0], sin_r};
        USR_SHR:   w_next = {sin_l, r_q[WIDTH-1:1]};
        USR_ROL:   w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        USR_ROR:   w_next = {r_q[0], r_q[WIDTH-1:1]};
        USR_LOAD:  w_next = pdata_in;
        USR_CLEAR: w_next = '0;
        default:   w_next = r_q;
      endcase
    end
  end
  // data register
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) r_q <= RESET_VAL;
    else       r_q <= w_next;
  end
  assign w_inc = en && (mode == USR_SHL || mode == USR_SHR);
  assign w_clr = en && (mode == USR_LOAD || mode == USR_CLEAR);
  usr_shift_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk          (clk),
    .rst          (w_rst),
    .i_inc        (w_inc),
    .i_clr        (w_clr),
    .o_cnt        (shift_cnt),
    .o_word_valid (word_valid)
  );
  assign q        = r_q;
  assign sout_msb = r_q[WIDTH-1];
  assign sout_lsb = r_q[0];
`ifdef USR_PARITY_EN
  assign parity = ^r_q;
`else
  assign parity = 1'b0;
`endif
endmodule
